// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage action decoder.
// The same package is imported by instruction_fetch and instruction_decode.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam int          IMEM_WORDS = 256;
    localparam int          IMEM_AW    = $clog2(IMEM_WORDS);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_HALTED,
        ACT_FETCH
    } fetch_action_e;

    // The earliest matching rule wins; a redirect outranks a stall and a pending halt.
    function automatic fetch_action_e next_action(
        input logic advance,
        input logic redirect,
        input logic stall,
        input logic halted
    );
        if (!advance)      return ACT_HOLD;
        else if (redirect) return ACT_REDIRECT;
        else if (stall)    return ACT_STALL;
        else if (halted)   return ACT_HALTED;
        else               return ACT_FETCH;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: one synchronous write port for the debug loader and
// one combinational read port for fetch.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int DEPTH   = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [NB_DATA-1:0]       i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [NB_DATA-1:0]       o_rdata
);

    logic [NB_DATA-1:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents come only from the loader, and a
    // reset branch would stop it from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC priority selection, sticky halt flag and the
// IF/ID pipeline register that feeds instruction_decode.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_PC      = 32,
    parameter int IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_stall,
    input  logic                          i_redirect,
    input  logic [NB_PC-1:0]              i_target,
    input  logic                          i_load_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] i_load_addr,
    input  logic [NB_DATA-1:0]            i_load_data,
    output logic [NB_DATA-1:0]            o_instruction,
    output logic [NB_PC-1:0]              o_pcounter4,
    output logic [NB_PC-1:0]              o_pc,
    output logic                          o_valid,
    output logic                          o_halt
);

    localparam int AW = $clog2(IMEM_WORDS);

    logic [NB_PC-1:0]   pc;
    logic [NB_PC-1:0]   pc_plus4;
    logic [NB_DATA-1:0] word;
    logic               word_is_halt;
    fetch_action_e      action;

    // PC[1:0] never reach the memory; the word index wraps modulo IMEM_WORDS.
    instruction_memory #(
        .NB_DATA (NB_DATA),
        .DEPTH   (IMEM_WORDS)
    ) u_imem (
        .clk     (clk),
        .i_we    (i_load_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (pc[AW+1:2]),
        .o_rdata (word)
    );

    assign pc_plus4     = pc + NB_PC'(4);
    assign word_is_halt = (word == NB_DATA'(HALT_INSTR));
    // A loader write freezes fetch, so a same-cycle read of the written word cannot occur.
    assign action       = next_action(i_enable & ~i_load_we, i_redirect, i_stall, o_halt);
    assign o_pc         = pc;

    // NOTE: every register here uses non-blocking assignment so all next-state values are
    // computed from the pre-edge state, which is what the priority rules assume.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc            <= '0;
            o_instruction <= NB_DATA'(NOP_INSTR);
            o_pcounter4   <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    pc            <= {i_target[NB_PC-1:2], 2'b00};
                    o_instruction <= NB_DATA'(NOP_INSTR);
                    o_pcounter4   <= '0;
                    o_valid       <= 1'b0;
                    o_halt        <= 1'b0;
                end
                ACT_HALTED: begin
                    o_instruction <= NB_DATA'(NOP_INSTR);
                    o_pcounter4   <= '0;
                    o_valid       <= 1'b0;
                end
                ACT_FETCH: begin
                    o_instruction <= word;
                    o_pcounter4   <= pc_plus4;
                    o_valid       <= 1'b1;
                    // HALT is latched into IF/ID but the PC stays parked on it.
                    if (word_is_halt) begin
                        o_halt <= 1'b1;
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                default: begin
                    // ACT_HOLD and ACT_STALL keep PC, IF/ID and the halt flag.
                end
            endcase
        end
    end

endmodule
